// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the load/store path: FSM encoding, byte-lane constants.
package cpu_mem_pkg;

    localparam int BYTE_W = 8;

    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RD   = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        RD   = ST_RD,
        WR   = ST_WR,
        RESP = ST_RESP
    } lsuState_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane helper: extracts a sign/zero-extended byte from a word,
// and merges a byte into a word for read-modify-write stores.
module lsu_byte_lane
    import cpu_mem_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] word,
    input  logic              lane,
    input  logic              signExt,
    input  logic [BYTE_W-1:0] byteIn,
    output logic [DATA_W-1:0] extracted,
    output logic [DATA_W-1:0] merged
);

    logic [BYTE_W-1:0] laneByte;

    assign laneByte = (lane == LANE_HI) ? word[2*BYTE_W-1:BYTE_W] : word[BYTE_W-1:0];

    always_comb begin
        extracted = '0;
        extracted[BYTE_W-1:0] = laneByte;
        if (signExt) begin
            extracted[DATA_W-1:BYTE_W] = {(DATA_W-BYTE_W){laneByte[BYTE_W-1]}};
        end
    end

    always_comb begin
        merged = word;
        if (lane == LANE_HI) begin
            merged[2*BYTE_W-1:BYTE_W] = byteIn;
        end else begin
            merged[BYTE_W-1:0] = byteIn;
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between execute and a word-only data memory. Adds byte loads
// (sign/zero-extended) and byte stores via read-modify-write.
module load_store_unit
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_byte,
    input  logic              req_signed,
    input  logic [ADDR_W:0]   req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] addrM,
    output logic              write_en,
    output logic [DATA_W-1:0] write_dataM,
    input  logic [DATA_W-1:0] read_dataM
);

    lsuState_t         stateReg, stateNext;
    logic              weReg, byteReg, signedReg, laneReg;
    logic [BYTE_W-1:0] wbyteReg;
    logic [ADDR_W-1:0] addrReg;
    logic [DATA_W-1:0] wdataMReg;
    logic [DATA_W-1:0] respDataReg;
    logic [DATA_W-1:0] laneExtracted, laneMerged;

    lsu_byte_lane #(.DATA_W(DATA_W)) byteLane (
        .word      (read_dataM),
        .lane      (laneReg),
        .signExt   (signedReg),
        .byteIn    (wbyteReg),
        .extracted (laneExtracted),
        .merged    (laneMerged)
    );

    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            IDLE: if (req_valid) stateNext = (req_we && !req_byte) ? WR : RD;
            RD:   stateNext = weReg ? WR : RESP;
            WR:   stateNext = RESP;
            RESP: if (resp_ready) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg    <= IDLE;
            weReg       <= 1'b0;
            byteReg     <= 1'b0;
            signedReg   <= 1'b0;
            laneReg     <= LANE_LO;
            wbyteReg    <= '0;
            addrReg     <= '0;
            wdataMReg   <= '0;
            respDataReg <= '0;
        end else begin
            stateReg <= stateNext;
            case (stateReg)
                IDLE: if (req_valid) begin
                    weReg     <= req_we;
                    byteReg   <= req_byte;
                    signedReg <= req_signed;
                    laneReg   <= req_addr[0];
                    wbyteReg  <= req_wdata[BYTE_W-1:0];
                    addrReg   <= req_addr[ADDR_W:1];
                    if (req_we && !req_byte) wdataMReg <= req_wdata;
                end
                // Memory read data is valid combinationally off addrM here.
                RD: begin
                    if (weReg) wdataMReg <= laneMerged;
                    else respDataReg <= byteReg ? laneExtracted : read_dataM;
                end
                WR: respDataReg <= '0;
                default: ;
            endcase
        end
    end

    assign req_ready   = (stateReg == IDLE);
    assign resp_valid  = (stateReg == RESP);
    assign resp_data   = respDataReg;
    assign addrM       = addrReg;
    assign write_dataM = wdataMReg;
    // Gating with reset guarantees an aborted store never reaches memory.
    assign write_en    = (stateReg == WR) && !reset;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a 16-word falling-edge-write memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_byte, req_signed;
    logic [4:0]  req_addr;
    logic [15:0] req_wdata;
    logic        resp_valid, resp_ready;
    logic [15:0] resp_data;
    logic [3:0]  addrM;
    logic        write_en;
    logic [15:0] write_dataM, read_dataM;

    logic [15:0] mem [16];
    int cycle = 0;
    int checks = 0;
    int errors = 0;
    int wenCount = 0;
    logic [15:0] lastWdata = '0;
    bit seen = 0;

    typedef struct {
        string       name;
        logic [15:0] data;
        int          lat;
        int          acc;
    } exp_t;
    exp_t expQ[$];

    load_store_unit #(.ADDR_W(4), .DATA_W(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .addrM(addrM), .write_en(write_en),
        .write_dataM(write_dataM), .read_dataM(read_dataM)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle <= cycle + 1;

    assign read_dataM = mem[addrM];
    always @(negedge clk) if (write_en) mem[addrM] <= write_dataM;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // Monitor: latency on first valid, data on handshake.
    always @(negedge clk) begin
        if (write_en) begin
            wenCount++;
            lastWdata = write_dataM;
        end
        if (!reset && resp_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got data %h expected no response", resp_data);
            end else begin
                if (!seen) begin
                    chk({expQ[0].name, "_latency"}, 16'(cycle - expQ[0].acc), 16'(expQ[0].lat));
                    seen = 1;
                end
                if (resp_ready) begin
                    chk({expQ[0].name, "_data"}, resp_data, expQ[0].data);
                    $display("txn %s: resp_data=%h", expQ[0].name, resp_data);
                    void'(expQ.pop_front());
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input string nm, input logic we, input logic byt, input logic sgn,
                         input logic [4:0] addr, input logic [15:0] wd,
                         input logic [15:0] expData, input int expLat, input bit push);
        int n;
        exp_t e;
        req_valid = 1; req_we = we; req_byte = byt; req_signed = sgn;
        req_addr = addr; req_wdata = wd;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL %s_accept: got req_ready=0 expected 1 within 50 cycles", nm);
            req_valid = 0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 0;
        if (push) begin
            e.name = nm; e.data = expData; e.lat = expLat; e.acc = cycle;
            expQ.push_back(e);
        end
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d pending responses expected 0", nm, expQ.size());
            expQ.delete();
            seen = 0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, n;
        logic [15:0] held;
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2] = 16'h2222; mem[3] = 16'h2233; mem[15] = 16'h8899;
        reset = 1; req_valid = 0; req_we = 0; req_byte = 0; req_signed = 0;
        req_addr = '0; req_wdata = '0; resp_ready = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {15'b0, resp_valid}, 16'h0000);
        chk("rst_resp_data", resp_data, 16'h0000);
        chk("rst_addrM", {12'b0, addrM}, 16'h0000);
        chk("rst_write_dataM", write_dataM, 16'h0000);
        chk("rst_write_en", {15'b0, write_en}, 16'h0000);
        chk("rst_req_ready", {15'b0, req_ready}, 16'h0001);
        @(posedge clk); #1; reset = 0;

        // Word load, no writes expected
        w0 = wenCount;
        issue("ld_w6", 0, 0, 0, 5'd6, 16'h0, 16'h2233, 1, 1);
        drain("ld_w6");
        chk("ld_w6_no_write", 16'(wenCount - w0), 16'h0000);

        issue("ldb_31_s", 0, 1, 1, 5'd31, 16'h0, 16'hFF88, 1, 1);
        drain("ldb_31_s");
        issue("ldb_31_u", 0, 1, 0, 5'd31, 16'h0, 16'h0088, 1, 1);
        drain("ldb_31_u");
        issue("ldb_30_s", 0, 1, 1, 5'd30, 16'h0, 16'hFF99, 1, 1);
        drain("ldb_30_s");

        // Byte store aborted by reset while in WR
        issue("bst_abort", 1, 1, 0, 5'd5, 16'h00AB, 16'h0, 2, 0);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk);
        chk("abort_write_en", {15'b0, write_en}, 16'h0000);
        @(posedge clk); #1;
        reset = 0;
        @(negedge clk);
        chk("abort_req_ready", {15'b0, req_ready}, 16'h0001);
        chk("abort_resp_valid", {15'b0, resp_valid}, 16'h0000);
        chk("abort_mem2", mem[2], 16'h2222);
        $display("txn bst_abort: mem[2]=%h", mem[2]);
        @(posedge clk); #1;

        // Byte store read-modify-write
        w0 = wenCount;
        issue("bst_5", 1, 1, 0, 5'd5, 16'h00AB, 16'h0000, 2, 1);
        drain("bst_5");
        chk("bst_5_wen_cycles", 16'(wenCount - w0), 16'h0001);
        chk("bst_5_write_dataM", lastWdata, 16'hAB22);
        issue("ld_after_bst", 0, 0, 0, 5'd4, 16'h0, 16'hAB22, 1, 1);
        drain("ld_after_bst");

        // Word store
        w0 = wenCount;
        issue("st_0", 1, 0, 0, 5'd0, 16'hBEEF, 16'h0000, 1, 1);
        drain("st_0");
        chk("st_0_wen_cycles", 16'(wenCount - w0), 16'h0001);
        issue("ld_after_st", 0, 0, 0, 5'd0, 16'h0, 16'hBEEF, 1, 1);
        drain("ld_after_st");

        // Back-pressure with a waiting second request
        resp_ready = 0;
        issue("ld_hold", 0, 0, 0, 5'd4, 16'h0, 16'hAB22, 1, 1);
        req_valid = 1; req_we = 0; req_byte = 0; req_signed = 0; req_addr = 5'd6;
        n = 0;
        while (!resp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        held = resp_data;
        chk("hold_first_data", held, 16'hAB22);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("hold_resp_valid", {15'b0, resp_valid}, 16'h0001);
            chk("hold_resp_data", resp_data, held);
            chk("hold_req_ready", {15'b0, req_ready}, 16'h0000);
            chk("hold_write_en", {15'b0, write_en}, 16'h0000);
        end
        @(posedge clk); #1;
        resp_ready = 1;
        issue("ld_after_hold", 0, 0, 0, 5'd6, 16'h0, 16'h2233, 1, 1);
        drain("ld_after_hold");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
